// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP datapath stages.
// Build option: DENSE_SATURATE_EN selects clamping instead of wrapping in narrow().
package mlp_pkg;

    localparam int FP_W = 16;
    localparam int FP_F = 8;
    localparam int WIDE_BITS = 64;

    typedef logic signed [FP_W-1:0] fp_t;
    typedef logic signed [WIDE_BITS-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCUM,
        FINISH
    } state_t;

    // Accumulator width that cannot overflow over n full-width products.
    function automatic int acc_bits(input int total, input int n);
        return 2 * total + $clog2(n) + 1;
    endfunction

    // Narrow a sign-extended value to 'bits' wide; the caller keeps the low bits.
    function automatic wide_t narrow(input wide_t v, input int bits);
`ifdef DENSE_SATURATE_EN
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
`else
        return (v <<< (WIDE_BITS - bits)) >>> (WIDE_BITS - bits);
`endif
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate lane; clear preloads the bias at output scale.
module mac_unit
    import mlp_pkg::*;
#(
    parameter int TOTAL = 16,
    parameter int FRAC  = 8,
    parameter int ACC   = 35
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [TOTAL-1:0] bias,
    input  logic signed [TOTAL-1:0] a,
    input  logic signed [TOTAL-1:0] b,
    output logic signed [ACC-1:0]   acc_out
);

    logic signed [2*TOTAL-1:0] prod;
    logic signed [ACC-1:0]     bias_ext;
    logic signed [ACC-1:0]     prod_ext;

    assign prod     = a * b;
    assign bias_ext = {{(ACC-TOTAL){bias[TOTAL-1]}}, bias};
    assign prod_ext = {{(ACC-2*TOTAL){prod[2*TOTAL-1]}}, prod};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out <= '0;
        end else if (clear) begin
            acc_out <= bias_ext <<< FRAC;
        end else if (en) begin
            acc_out <= acc_out + prod_ext;
        end
    end

endmodule

// File: rtl/dense_layer.sv
// Fully connected layer: one output per class from streamed activations/weights.
// Build option: DENSE_SATURATE_EN clamps outputs instead of wrapping.
module dense_layer
    import mlp_pkg::*;
#(
    parameter int NUM_INPUTS    = 784,
    parameter int NUM_CLASSES   = 4,
    parameter int FP_TOTAL_BITS = FP_W,
    parameter int FP_FRAC_BITS  = FP_F
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic signed [FP_TOTAL_BITS-1:0] bias [NUM_CLASSES],
    output logic [$clog2(NUM_INPUTS)-1:0]   rd_addr,
    output logic                            rd_en,
    input  logic signed [FP_TOTAL_BITS-1:0] x_data,
    input  logic signed [FP_TOTAL_BITS-1:0] w_data [NUM_CLASSES],
    output logic                            busy,
    output logic                            done,
    output logic signed [FP_TOTAL_BITS-1:0] layer_out [NUM_CLASSES]
);

    localparam int AW       = $clog2(NUM_INPUTS);
    localparam int ACC_BITS = acc_bits(FP_TOTAL_BITS, NUM_INPUTS);
    localparam logic [AW-1:0] LAST = AW'(NUM_INPUTS - 1);

    state_t state;
    state_t next;
    logic [AW-1:0] cnt;

    logic signed [ACC_BITS-1:0]      acc     [NUM_CLASSES];
    logic signed [ACC_BITS-1:0]      shifted [NUM_CLASSES];
    logic signed [FP_TOTAL_BITS-1:0] res     [NUM_CLASSES];

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = LOAD;
            LOAD:    next = ACCUM;
            ACCUM:   if (cnt == LAST) next = FINISH;
            FINISH:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= next;
            busy  <= (next != IDLE);
            done  <= (state == FINISH);
            cnt   <= (state == ACCUM) ? cnt + 1'b1 : '0;
            // Addresses run one cycle ahead of the data they return.
            if (state == IDLE && start) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (rd_en) begin
                if (rd_addr == LAST) begin
                    rd_en <= 1'b0;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_CLASSES; j++) begin : g_mac
        mac_unit #(
            .TOTAL (FP_TOTAL_BITS),
            .FRAC  (FP_FRAC_BITS),
            .ACC   (ACC_BITS)
        ) u_mac (
            .clk     (clk),
            .reset   (reset),
            .clear   (state == LOAD),
            .en      (state == ACCUM),
            .bias    (bias[j]),
            .a       (x_data),
            .b       (w_data[j]),
            .acc_out (acc[j])
        );

        assign shifted[j] = acc[j] >>> FP_FRAC_BITS;
        assign res[j] = FP_TOTAL_BITS'(narrow(wide_t'(shifted[j]), FP_TOTAL_BITS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
                layer_out[j] <= '0;
            end
        end else if (state == FINISH) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
                layer_out[j] <= res[j];
            end
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer with a 4-input, 2-class configuration.
module tb_dense_layer;

    localparam int N = 4;
    localparam int C = 2;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic signed [15:0] bias [C];
    logic [1:0] rd_addr;
    logic rd_en;
    logic signed [15:0] x_data;
    logic signed [15:0] w_data [C];
    logic busy;
    logic done;
    logic signed [15:0] layer_out [C];

    logic signed [15:0] xmem [N];
    logic signed [15:0] wmem [N][C];

    int vectors = 0;
    int miscompares = 0;

    dense_layer #(
        .NUM_INPUTS    (N),
        .NUM_CLASSES   (C),
        .FP_TOTAL_BITS (16),
        .FP_FRAC_BITS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .x_data    (x_data),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .layer_out (layer_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xmem[rd_addr];
            for (int c = 0; c < C; c++) w_data[c] <= wmem[rd_addr][c];
        end
    end

    task automatic set_uniform(input logic [15:0] x, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] b);
        for (int i = 0; i < N; i++) begin
            xmem[i] = x;
            wmem[i][0] = w0;
            wmem[i][1] = w1;
        end
        bias[0] = b;
        bias[1] = b;
    endtask

    task automatic run_check(input string name, input logic [15:0] e0,
                             input logic [15:0] e1, input bit chk_addr);
        int done_k;
        int naddr;
        logic [1:0] addrs [8];
        done_k = -1;
        naddr = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                vectors++;
                if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 2'd0) begin
                    miscompares++;
                    $display("FAIL %s load: busy=%b rd_en=%b rd_addr=%0d expected 1 1 0",
                             name, busy, rd_en, rd_addr);
                end
            end
            if (rd_en === 1'b1 && naddr < 8) begin
                addrs[naddr] = rd_addr;
                naddr++;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        vectors++;
        if (done_k !== 7) begin
            miscompares++;
            $display("FAIL %s latency: done at T+%0d expected T+7", name, done_k);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        end
        vectors++;
        if (layer_out[0] !== e0) begin
            miscompares++;
            $display("FAIL %s out0: got %h expected %h", name, layer_out[0], e0);
        end
        vectors++;
        if (layer_out[1] !== e1) begin
            miscompares++;
            $display("FAIL %s out1: got %h expected %h", name, layer_out[1], e1);
        end
        if (chk_addr) begin
            vectors++;
            if (naddr !== 4 || addrs[0] !== 2'd0 || addrs[1] !== 2'd1 ||
                addrs[2] !== 2'd2 || addrs[3] !== 2'd3) begin
                miscompares++;
                $display("FAIL %s rd_addr_seq: got %0d reads expected 4 reads 0,1,2,3",
                         name, naddr);
            end
        end
    endtask

    task automatic check_zeroed(input string name);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 2'd0 ||
            layer_out[0] !== 16'h0 || layer_out[1] !== 16'h0) begin
            miscompares++;
            $display("FAIL %s: done=%b busy=%b rd_en=%b rd_addr=%0d out=%h,%h expected all 0",
                     name, done, busy, rd_en, rd_addr, layer_out[0], layer_out[1]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        set_uniform(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        check_zeroed("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_basic;
        set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0040);
        run_check("basic", 16'h0240, 16'h0240, 1'b1);
    endtask

    task automatic test_negative;
        set_uniform(16'h0100, 16'h0080, 16'hFF80, 16'h0040);
        run_check("negative", 16'h0240, 16'hFE40, 1'b0);
    endtask

    task automatic test_ordering;
        xmem[0] = 16'h0100;
        xmem[1] = 16'h0200;
        xmem[2] = 16'hFF00;
        xmem[3] = 16'h0080;
        for (int i = 0; i < N; i++) begin
            wmem[i][0] = 16'h0100;
            wmem[i][1] = (i == 0) ? 16'h0100 : 16'h0000;
        end
        bias[0] = 16'h0000;
        bias[1] = 16'h0010;
        run_check("ordering", 16'h0280, 16'h0110, 1'b0);
    endtask

    task automatic test_overflow;
        set_uniform(16'h7F00, 16'h7F00, 16'h7F00, 16'h0000);
`ifdef DENSE_SATURATE_EN
        run_check("overflow", 16'h7FFF, 16'h7FFF, 1'b0);
`else
        run_check("overflow", 16'h0400, 16'h0400, 1'b0);
`endif
    endtask

    task automatic test_truncation;
        set_uniform(16'h0001, 16'h0080, 16'h0080, 16'h0000);
        run_check("truncation", 16'h0002, 16'h0002, 1'b0);
    endtask

    task automatic test_reset_mid;
        int ndone;
        ndone = 0;
        set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0040);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check_zeroed("reset_mid");
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", ndone);
        end
        run_check("after_reset", 16'h0240, 16'h0240, 1'b0);
    endtask

    task automatic test_start_handling;
        int ndone;
        int first_k;
        int second_k;
        ndone = 0;
        first_k = -1;
        second_k = -1;
        set_uniform(16'h0100, 16'h0080, 16'hFF80, 16'h0040);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 2 || k == 4) ? 1'b1 : 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first_k < 0) first_k = k;
            end
        end
        vectors++;
        if (ndone !== 1 || first_k !== 7) begin
            miscompares++;
            $display("FAIL start_ignored: got %0d dones first at T+%0d expected 1 at T+7",
                     ndone, first_k);
        end
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        first_k = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                first_k = k;
                break;
            end
        end
        set_uniform(16'h0100, 16'h0080, 16'h0080, 16'h0040);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                second_k = k;
                break;
            end
        end
        vectors++;
        if (first_k !== 7 || second_k !== 7) begin
            miscompares++;
            $display("FAIL start_at_done: runs done at T+%0d and T+%0d expected 7 and 7",
                     first_k, second_k);
        end
        vectors++;
        if (layer_out[0] !== 16'h0240 || layer_out[1] !== 16'h0240) begin
            miscompares++;
            $display("FAIL start_at_done_result: got %h,%h expected 0240,0240",
                     layer_out[0], layer_out[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ordering();
        test_overflow();
        test_truncation();
        test_reset_mid();
        test_start_handling();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dense_layer.md
# dense_layer

Fully connected layer stage that computes one output per class, `layer_out[j] = bias[j] + Σ x[i]·W[i][j]`, in signed fixed point. It sits directly upstream of the ReLU stage: its `layer_out` array and `done` pulse drive the ReLU's `input_vector` and `start`. It streams the activation vector and weight rows from external synchronous memories, one input index per cycle, with NUM_CLASSES parallel MACs.

## Interface
- NUM_INPUTS, 784, length of the activation vector.
- NUM_CLASSES, 4, number of outputs; also the number of parallel MACs.
- FP_TOTAL_BITS, 16, width of activations, weights, bias and outputs.
- FP_FRAC_BITS, 8, fractional bits; all operands share this format.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only when idle.
- bias  in  signed FP_TOTAL_BITS × NUM_CLASSES  per-class bias; must be held stable from start until done.
- rd_addr  out  clog2(NUM_INPUTS)  shared read address for the activation and weight memories.
- rd_en  out  1  read strobe.
- x_data  in  signed FP_TOTAL_BITS  activation x[rd_addr]; valid one cycle after the address.
- w_data  in  signed FP_TOTAL_BITS × NUM_CLASSES  weight row W[rd_addr][*]; valid one cycle after the address.
- busy  out  1  high from start acceptance until the cycle before done.
- done  out  1  one-cycle pulse; `layer_out` is valid from this cycle.
- layer_out  out  signed FP_TOTAL_BITS × NUM_CLASSES  result; held until the next done or reset.

## Operation
- **States:** IDLE, LOAD, ACCUM, FINISH.
- **IDLE:**
  - start=1 → LOAD.
  - start while busy is ignored.
  - start in the done cycle is accepted.
- **LOAD (1 cycle):**
  - acc[j] ← sign-extended bias[j] << FP_FRAC_BITS.
  - rd_addr=0, rd_en=1.
  - Next state: ACCUM.
- **ACCUM (NUM_INPUTS cycles):**
  - Each cycle, acc[j] += x_data·w_data[j], using the full 2·FP_TOTAL_BITS product.
  - rd_addr increments each cycle while rd_en=1.
  - rd_en drops after address NUM_INPUTS-1 has been issued.
  - After the last product is accumulated, next state: FINISH.
- **FINISH (1 cycle):**
  - Arithmetic shift right of acc[j] by FP_FRAC_BITS (truncation toward −∞).
  - Narrow to FP_TOTAL_BITS per the Configuration section.
  - Register the result into layer_out[j], pulse done, return to IDLE.
- **Accumulator width:** ACC_BITS = 2·FP_TOTAL_BITS + clog2(NUM_INPUTS) + 1. The accumulator never overflows internally.
- **Reset** at any time, including mid-ACCUM:
  - state=IDLE, acc=0.
  - layer_out all 0.
  - done=0, busy=0, rd_en=0, rd_addr=0.
  - Partial results are discarded.

## Timing
- start accepted at cycle T.
- T+1: LOAD; rd_addr=0 and rd_en=1 are driven.
- T+2 … T+NUM_INPUTS+1: accumulate data for addresses 0 … NUM_INPUTS-1.
- T+NUM_INPUTS+2: FINISH.
- T+NUM_INPUTS+3: done=1, layer_out valid, busy=0.
- Latency from start to done: NUM_INPUTS+3 cycles.
- busy=1 from T+1 through T+NUM_INPUTS+2.
- All outputs are registered.

## Configuration
- **DENSE_SATURATE_EN defined:** the shifted accumulator is clamped to [−2^(FP_TOTAL_BITS−1), 2^(FP_TOTAL_BITS−1)−1] (0x8000 … 0x7FFF at 16 bits).
- **DENSE_SATURATE_EN undefined:** the result is truncated to its low FP_TOTAL_BITS bits (two's-complement wrap), and the clamp logic is omitted.

## Structure
- **Shared package `mlp_pkg`:**
  - fp_t typedef (signed FP_TOTAL_BITS).
  - acc_t width helper.
  - State enum.
  - A saturate/narrow function.
- **Sub-module `mac_unit`:**
  - One per class, instanced via generate.
  - Ports: clk, reset, clear (loads bias), en, a, b, acc_out.

## Test plan
Parameters NUM_INPUTS=4, NUM_CLASSES=2, 16/8 format unless noted.
1. **Basic positive:** x=0x0100 (1.0) all, W=0x0080 (0.5) all, bias=0x0040 → layer_out={0x0240, 0x0240}; done exactly at T+7; rd_addr sequence 0, 1, 2, 3.
2. **Negative result:** W=0xFF80 (−0.5), bias=0x0040 → 0xFE40 (−1.75).
3. **Overflow:** x=W=0x7F00, bias=0 → 0x7FFF with DENSE_SATURATE_EN; 0x0400 without.
4. **Reset mid-operation:** reset asserted at T+4 → all outputs 0 next cycle; no done pulse. A new start then produces the scenario-1 result.
5. **Start handling:** start pulses during busy are ignored (exactly one done). A start coincident with done launches a second run, whose done arrives 7 cycles later.
6. **Truncation:** x=0x0001, W=0x0080, bias=0 → each product is 0x80 (frac 16); the sum 0x200 >> 8 = 0x0002.
